// File: rtl/irq_pkg.sv
// Shared constants for the machine interrupt source block:
// register offsets, mcause codes, source indices and FSM states.
package irq_pkg;

    localparam logic [4:0] ADDR_MSIP   = 5'h00;
    localparam logic [4:0] ADDR_CMP_LO = 5'h08;
    localparam logic [4:0] ADDR_CMP_HI = 5'h0C;
    localparam logic [4:0] ADDR_TIM_LO = 5'h10;
    localparam logic [4:0] ADDR_TIM_HI = 5'h14;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    localparam logic [1:0] SRC_MSI = 2'd0;
    localparam logic [1:0] SRC_MTI = 2'd1;
    localparam logic [1:0] SRC_MEI = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACKED
    } irq_state_e;

    function automatic logic [31:0] cause_of(input logic [1:0] src);
        logic [31:0] c;
        c = CAUSE_MTI;
        unique case (src)
            SRC_MEI: c = CAUSE_MEI;
            SRC_MSI: c = CAUSE_MSI;
            default: c = CAUSE_MTI;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Flop chain bringing the asynchronous external interrupt
// level into the clk domain; clears to 0 on reset.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt sources (mtime/mtimecmp, msip, external line),
// fixed-priority arbitration and a request held until acknowledged.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq_in,
    input  logic [2:0]  mie_en,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic [2:0]  mip_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;
    logic          tick;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic          mtip;
    logic          meip;
    logic [2:0]    mip;
    logic [3:0]    elig;
    logic [1:0]    win;
    logic          src_live;

    irq_state_e    state;
    irq_state_e    state_n;
    logic [1:0]    src;
    logic [1:0]    src_n;
    logic [31:0]   cause;
    logic [31:0]   cause_n;

    logic wr_msip;
    logic wr_cmp_lo;
    logic wr_cmp_hi;
    logic wr_tim_lo;
    logic wr_tim_hi;

    assign wr_msip   = bus_we && (bus_addr == ADDR_MSIP);
    assign wr_cmp_lo = bus_we && (bus_addr == ADDR_CMP_LO);
    assign wr_cmp_hi = bus_we && (bus_addr == ADDR_CMP_HI);
    assign wr_tim_lo = bus_we && (bus_addr == ADDR_TIM_LO);
    assign wr_tim_hi = bus_we && (bus_addr == ADDR_TIM_HI);

    assign tick = (pcnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // A bus write to either half suppresses that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr_tim_lo) begin
            mtime[31:0] <= bus_wdata;
        end else if (wr_tim_hi) begin
            mtime[63:32] <= bus_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
            mtip     <= 1'b0;
        end else begin
            if (wr_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
            if (wr_cmp_hi) mtimecmp[63:32] <= bus_wdata;
            if (wr_msip)   msip            <= bus_wdata[0];
            mtip <= (mtime >= mtimecmp);
        end
    end

    irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_irq_in),
        .q   (meip)
    );

    assign mip     = {meip, mtip, msip};
    assign mip_out = mip;
    assign elig    = {1'b0, mip & mie_en};

    always_comb begin
        win = SRC_MTI;
        priority case (1'b1)
            elig[SRC_MEI]: win = SRC_MEI;
            elig[SRC_MSI]: win = SRC_MSI;
            default:       win = SRC_MTI;
        endcase
    end

    assign src_live = elig[src];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            src   <= SRC_MSI;
            cause <= '0;
        end else begin
            state <= state_n;
            src   <= src_n;
            cause <= cause_n;
        end
    end

    // Ack beats withdrawal; ACKED holds until the source goes quiet.
    always_comb begin
        state_n = state;
        src_n   = src;
        cause_n = cause;
        unique case (state)
            ST_IDLE: begin
                if (|elig) begin
                    state_n = ST_PEND;
                    src_n   = win;
                    cause_n = cause_of(win);
                end
            end
            ST_PEND: begin
                if (irq_ack) begin
                    state_n = ST_ACKED;
                end else if (!src_live) begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACKED: begin
                if (!src_live) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign irq_req   = (state == ST_PEND);
    assign irq_cause = cause;

    always_comb begin
        bus_rdata = '0;
        unique case (bus_addr)
            ADDR_MSIP:   bus_rdata = {31'b0, msip};
            ADDR_CMP_LO: bus_rdata = mtimecmp[31:0];
            ADDR_CMP_HI: bus_rdata = mtimecmp[63:32];
            ADDR_TIM_LO: bus_rdata = mtime[31:0];
            ADDR_TIM_HI: bus_rdata = mtime[63:32];
            default:     bus_rdata = '0;
        endcase
    end

endmodule
